// File: rtl/force_cache_accum_pkg.sv
// force_cache_accum_pkg: shared constants, beat field offsets, FSM encoding and saturating add
// Contents: cell/lane geometry, input beat layout {sub, id, fz, fy, fx}, state codes, sat_add()
package force_cache_accum_pkg;
    localparam int DATA_WIDTH            = 32;
    localparam int PARTICLE_ID_WIDTH     = 7;
    localparam int NUM_PARTICLE_PER_CELL = 100;
    localparam int NUM_FILTER            = 7;
    localparam int FORCE_BUFFER_WIDTH    = 3*DATA_WIDTH+PARTICLE_ID_WIDTH+1;
    localparam int FORCE_CACHE_WIDTH     = 3*DATA_WIDTH;
    localparam int FX_LSB  = 0;
    localparam int FY_LSB  = DATA_WIDTH;
    localparam int FZ_LSB  = 2*DATA_WIDTH;
    localparam int ID_LSB  = 3*DATA_WIDTH;
    localparam int SUB_BIT = FORCE_BUFFER_WIDTH-1;
    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;
    typedef logic [DATA_WIDTH-1:0] comp_t;
    // Returns {saturated, result}; one guard bit detects signed overflow.
    function automatic logic [DATA_WIDTH:0] sat_add(input comp_t a, input comp_t b, input logic sub);
        logic [DATA_WIDTH:0] s;
        s = sub ? {a[DATA_WIDTH-1], a} - {b[DATA_WIDTH-1], b} : {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
        return (s[DATA_WIDTH] != s[DATA_WIDTH-1]) ? {1'b1, s[DATA_WIDTH], {(DATA_WIDTH-1){~s[DATA_WIDTH]}}}
                                                  : {1'b0, s[DATA_WIDTH-1:0]};
    endfunction
endpackage

// File: rtl/force_cache_accum_rr_arbiter.sv
// force_cache_accum_rr_arbiter: round-robin arbiter, one-hot grant searched from a rotating pointer
// Ports: clk, rst (sync, active-low), req[N] requests, grant[N] one-hot or zero
module force_cache_accum_rr_arbiter #(
    parameter int N = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);
    localparam int IW = $clog2(N);
    logic [IW-1:0] ptr, idx;
    // Scan downwards so the request closest to ptr is the last one written.
    always_comb begin
        idx = ptr;
        grant = '0;
        for (int k = N-1; k >= 0; k--)
            if (req[(int'(ptr)+k) % N]) idx = IW'((int'(ptr)+k) % N);
        if (|req) grant[idx] = 1'b1;
    end
    always_ff @(posedge clk)
        if (!rst) ptr <= '0;
        else if (|req) ptr <= (idx == IW'(N-1)) ? '0 : idx + 1'b1;
endmodule

// File: rtl/force_cache_accum.sv
// force_cache_accum: per-cell force accumulator with round-robin lane intake and clear-on-read cache
// Ports: clk, rst (sync, active-low); force_data/force_valid/force_ack lane intake;
//        reading_done, iter_start, accum_done iteration control;
//        cache_rd_en/cache_rd_addr -> cache_rd_data/cache_rd_valid read port (DONE only);
//        sat_flag, id_error sticky status
module force_cache_accum
    import force_cache_accum_pkg::*;
(
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_FILTER*FORCE_BUFFER_WIDTH-1:0] force_data,
    input  logic [NUM_FILTER-1:0]                     force_valid,
    output logic [NUM_FILTER-1:0]                     force_ack,
    input  logic                                      reading_done,
    input  logic                                      iter_start,
    output logic                                      accum_done,
    input  logic                                      cache_rd_en,
    input  logic [PARTICLE_ID_WIDTH-1:0]              cache_rd_addr,
    output logic [FORCE_CACHE_WIDTH-1:0]              cache_rd_data,
    output logic                                      cache_rd_valid,
    output logic                                      sat_flag,
    output logic                                      id_error
);
    localparam int DW = DATA_WIDTH;
    localparam int PW = PARTICLE_ID_WIDTH;
    localparam int CW = FORCE_CACHE_WIDTH;
    localparam int FBW = FORCE_BUFFER_WIDTH;
    localparam logic [PW-1:0] LAST_ID = PW'(NUM_PARTICLE_PER_CELL-1);
    logic [1:0] state, state_nx;
    logic [PW-1:0] clr_cnt, rd_addr, wr_addr, s1_id, s2_id, w_id;
    logic drain_cnt, granted, beat_ok, rd_req, rd_ok, wr_en;
    logic s1_valid, s1_sub, s2_valid, s2_sub, s2_sat, w_valid;
    logic [FBW-1:0] lane;
    logic [NUM_FILTER-1:0] req;
    logic [CW-1:0] mem [NUM_PARTICLE_PER_CELL];
    logic [CW-1:0] rd_q, wr_data, s1_f, s1_old, s2_f, s2_old, s2_sum, w_data;
    logic [DW:0] rx, ry, rz;
    assign req = force_valid & {NUM_FILTER{rst && state == ST_ACCUM}};
    force_cache_accum_rr_arbiter #(.N(NUM_FILTER)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .grant (force_ack)
    );
    always_comb begin
        lane = '0;
        for (int i = 0; i < NUM_FILTER; i++)
            lane = lane | (force_data[i*FBW +: FBW] & {FBW{force_ack[i]}});
    end
    assign granted = |force_ack;
    assign beat_ok = lane[ID_LSB +: PW] <= LAST_ID;
    // The single read port serves the S0 lookup in ACCUM and the user read in DONE.
    assign rd_req  = state == ST_DONE && cache_rd_en;
    assign rd_addr = state == ST_DONE ? cache_rd_addr : lane[ID_LSB +: PW];
    assign rd_ok   = rd_addr <= LAST_ID;
    // The RAM word read for S1 misses the result now in S2 and the one written on the
    // edge that performed the read (held in w_*); newest wins.
    assign s1_old = (s2_valid && s2_id == s1_id) ? s2_sum
                  : (w_valid && w_id == s1_id)   ? w_data : rd_q;
    assign rx = sat_add(s2_old[FX_LSB +: DW], s2_f[FX_LSB +: DW], s2_sub);
    assign ry = sat_add(s2_old[FY_LSB +: DW], s2_f[FY_LSB +: DW], s2_sub);
    assign rz = sat_add(s2_old[FZ_LSB +: DW], s2_f[FZ_LSB +: DW], s2_sub);
    assign s2_sum = {rz[DW-1:0], ry[DW-1:0], rx[DW-1:0]};
    assign s2_sat = rx[DW] | ry[DW] | rz[DW];
    assign wr_en   = state == ST_CLEAR || (rd_req && rd_ok) || s2_valid;
    assign wr_addr = state == ST_CLEAR ? clr_cnt : state == ST_DONE ? cache_rd_addr : s2_id;
    assign wr_data = (state == ST_CLEAR || state == ST_DONE) ? '0 : s2_sum;
    assign state_nx = state == ST_CLEAR ? (clr_cnt == LAST_ID ? ST_ACCUM : ST_CLEAR)
                    : state == ST_ACCUM ? (reading_done && !(|force_valid) ? ST_DRAIN : ST_ACCUM)
                    : state == ST_DRAIN ? (drain_cnt ? ST_DONE : ST_DRAIN)
                    : (iter_start ? ST_ACCUM : ST_DONE);
    assign accum_done = state == ST_DONE;
    assign cache_rd_data = cache_rd_valid ? rd_q : '0;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_CLEAR;
            clr_cnt <= '0;
            drain_cnt <= 1'b0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            w_valid <= 1'b0;
            cache_rd_valid <= 1'b0;
            sat_flag <= 1'b0;
            id_error <= 1'b0;
        end else begin
            state <= state_nx;
            clr_cnt <= state == ST_CLEAR ? clr_cnt + 1'b1 : '0;
            drain_cnt <= state == ST_DRAIN && !drain_cnt;
            s1_valid <= granted && beat_ok;
            s2_valid <= s1_valid;
            w_valid <= s2_valid;
            cache_rd_valid <= rd_req;
            sat_flag <= !(state == ST_DONE && iter_start) && (sat_flag || (s2_valid && s2_sat));
            id_error <= !(state == ST_DONE && iter_start) && (id_error || (granted && !beat_ok));
        end
    end
    always_ff @(posedge clk) begin
        s1_sub <= lane[SUB_BIT];
        s1_id <= lane[ID_LSB +: PW];
        s1_f <= lane[FX_LSB +: CW];
        s2_sub <= s1_sub;
        s2_id <= s1_id;
        s2_f <= s1_f;
        s2_old <= s1_old;
        w_id <= s2_id;
        w_data <= s2_sum;
        rd_q <= rd_ok ? mem[rd_addr] : '0;
        if (wr_en) mem[wr_addr] <= wr_data;
    end
endmodule

// File: tb/tb_force_cache_accum.sv
// tb_force_cache_accum: self-checking bench with a behavioural cache model and randomized lane traffic
module tb_force_cache_accum;
    import force_cache_accum_pkg::*;
    localparam int NF = NUM_FILTER;
    localparam int FBW = FORCE_BUFFER_WIDTH;
    localparam int NP = NUM_PARTICLE_PER_CELL;
    logic clk = 1'b0, rst = 1'b0;
    logic [NF*FBW-1:0] force_data = '0;
    logic [NF-1:0] force_valid = '0, force_ack;
    logic reading_done = 1'b0, iter_start = 1'b0, accum_done;
    logic cache_rd_en = 1'b0, cache_rd_valid, sat_flag, id_error;
    logic [6:0] cache_rd_addr = '0;
    logic [95:0] cache_rd_data;
    always #5 clk = ~clk;
    force_cache_accum dut (
        .clk(clk), .rst(rst), .force_data(force_data), .force_valid(force_valid),
        .force_ack(force_ack), .reading_done(reading_done), .iter_start(iter_start),
        .accum_done(accum_done), .cache_rd_en(cache_rd_en), .cache_rd_addr(cache_rd_addr),
        .cache_rd_data(cache_rd_data), .cache_rd_valid(cache_rd_valid),
        .sat_flag(sat_flag), .id_error(id_error)
    );
    int total = 0, bad = 0;
    // Behavioural model: phase 0 clear, 1 accumulate, 2 drain, 3 done.
    int mphase = 0, clr_seen = 0, drain_seen = 0, mptr = 0, g;
    logic signed [31:0] mc [NP][3];
    bit m_sat, m_iderr, rd_pend;
    logic [95:0] rd_exp;
    logic [NF-1:0] last_ack = '0, exp_ack;
    int ack_log[$];
    logic [FBW-1:0] bm [NF][64];
    int hd[NF], tl[NF];
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    function automatic logic [95:0] mword(input int a);
        return {mc[a][2], mc[a][1], mc[a][0]};
    endfunction
    task automatic apply_beat(input logic [FBW-1:0] b);
        int id;
        longint f, v;
        id = int'(b[ID_LSB +: 7]);
        if (id >= NP) m_iderr = 1;
        else for (int c = 0; c < 3; c++) begin
            f = longint'($signed(b[c*32 +: 32]));
            v = longint'(mc[id][c]) + (b[FBW-1] ? -f : f);
            if (v > 64'sh7FFFFFFF) begin v = 64'sh7FFFFFFF; m_sat = 1; end
            else if (v < -64'sh80000000) begin v = -64'sh80000000; m_sat = 1; end
            mc[id][c] = 32'(v);
        end
    endtask
    always @(negedge clk) begin
        last_ack = force_ack;
        for (int l = 0; l < NF; l++) if (force_ack[l]) ack_log.push_back(l);
        if (!rst) begin
            chk("rst_ack", force_ack, 0);
            chk("rst_outs", {accum_done, sat_flag, id_error, cache_rd_valid}, 0);
            chk("rst_rd_data", cache_rd_data, 0);
            mphase = 0; clr_seen = 0; mptr = 0; rd_pend = 0; m_sat = 0; m_iderr = 0;
            for (int a = 0; a < NP; a++) for (int c = 0; c < 3; c++) mc[a][c] = 0;
        end else begin
            chk("rd_valid", cache_rd_valid, rd_pend);
            if (rd_pend) chk("rd_data", cache_rd_data, rd_exp);
            rd_pend = 0;
            g = -1;
            exp_ack = '0;
            if (mphase == 1) begin
                for (int k = NF-1; k >= 0; k--) if (force_valid[(mptr+k)%NF]) g = (mptr+k)%NF;
                if (g >= 0) exp_ack[g] = 1'b1;
            end
            chk("ack", force_ack, exp_ack);
            chk("accum_done", accum_done, mphase == 3);
            case (mphase)
                0: begin clr_seen++; if (clr_seen == NP) mphase = 1; end
                1: begin
                    if (g >= 0) begin
                        apply_beat(force_data[g*FBW +: FBW]);
                        mptr = (g+1) % NF;
                    end
                    if (reading_done && force_valid == 0) begin mphase = 2; drain_seen = 0; end
                end
                2: begin drain_seen++; if (drain_seen == 2) mphase = 3; end
                default: begin
                    chk("sat_flag", sat_flag, m_sat);
                    chk("id_error", id_error, m_iderr);
                    if (cache_rd_en) begin
                        rd_pend = 1;
                        rd_exp = int'(cache_rd_addr) < NP ? mword(int'(cache_rd_addr)) : '0;
                        if (int'(cache_rd_addr) < NP) for (int c = 0; c < 3; c++) mc[cache_rd_addr][c] = 0;
                    end
                    if (iter_start) begin mphase = 1; m_sat = 0; m_iderr = 0; end
                end
            endcase
        end
    end
    function automatic logic [FBW-1:0] mk(input bit sub, input int id, input int fz, input int fy, input int fx);
        return {sub, 7'(id), 32'(fz), 32'(fy), 32'(fx)};
    endfunction
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic clear_q;
        for (int l = 0; l < NF; l++) begin hd[l] = 0; tl[l] = 0; end
    endtask
    task automatic push(input int l, input logic [FBW-1:0] b);
        bm[l][tl[l]] = b;
        tl[l]++;
    endtask
    // Presents each lane's queue, holding a beat until its ack has been seen.
    task automatic run_lanes(input int budget, input string name);
        int n;
        bit busy;
        n = 0;
        forever begin
            step;
            busy = 0;
            for (int l = 0; l < NF; l++) begin
                if (last_ack[l]) hd[l]++;
                force_valid[l] = hd[l] < tl[l];
                if (hd[l] < tl[l]) begin force_data[l*FBW +: FBW] = bm[l][hd[l]]; busy = 1; end
            end
            if (!busy) break;
            if (++n > budget) begin
                total++; bad++;
                $display("FAIL %s: lanes still pending after %0d cycles", name, budget);
                force_valid = '0;
                break;
            end
        end
    endtask
    task automatic finish_iter;
        int n;
        step;
        reading_done = 1'b1;
        step;
        reading_done = 1'b0;
        for (n = 0; n < 8 && !accum_done; n++) step;
        if (!accum_done) begin
            total++; bad++;
            $display("FAIL drain_timeout: accum_done still 0 after %0d cycles", n);
        end
    endtask
    task automatic rd(input int a, output logic [95:0] d);
        step;
        cache_rd_en = 1'b1;
        cache_rd_addr = 7'(a);
        step;
        cache_rd_en = 1'b0;
        d = cache_rd_data;
    endtask
    task automatic pulse_iter;
        step;
        iter_start = 1'b1;
        step;
        iter_start = 1'b0;
        chk("iter_clear", {sat_flag, id_error, accum_done}, 0);
    endtask
    int exp_order[9] = '{0, 3, 6, 0, 3, 6, 0, 3, 6};
    logic [95:0] d;
    int l, f;
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        clear_q;
        repeat (4) step;
        for (int r = 0; r < 3; r++) begin
            push(0, mk(0, 5, 0, 0, 10));
            push(3, mk(0, 5, 0, 0, 10));
            push(6, mk(0, 5, 0, 0, 10));
        end
        ack_log.delete();
        rst = 1'b1;
        run_lanes(200, "run_rr");
        chk("ack_count", ack_log.size(), 9);
        if (ack_log.size() == 9) for (int i = 0; i < 9; i++) chk("ack_order", ack_log[i], exp_order[i]);
        clear_q;
        push(1, mk(0, 7, 0, 0, 100));
        push(1, mk(1, 7, 0, 0, 40));
        push(1, mk(0, 7, 0, 0, 1));
        run_lanes(20, "run_fwd");
        clear_q;
        push(2, mk(0, 2, 0, 0, 32'h7FFFFFF0));
        push(2, mk(0, 2, 0, 0, 32'h20));
        run_lanes(20, "run_sat");
        clear_q;
        push(4, mk(0, 120, 0, 0, 5));
        run_lanes(20, "run_bad_id");
        step;
        iter_start = 1'b1;
        step;
        iter_start = 1'b0;
        finish_iter;
        chk("lit_sat_flag", sat_flag, 1);
        chk("lit_id_error", id_error, 1);
        rd(5, d);   chk("lit_rd5", d, {32'd0, 32'd0, 32'd90});
        rd(5, d);   chk("lit_rd5_again", d, 0);
        rd(7, d);   chk("lit_rd7", d, {32'd0, 32'd0, 32'd61});
        rd(2, d);   chk("lit_rd2", d, {32'd0, 32'd0, 32'h7FFFFFFF});
        rd(120, d); chk("lit_rd120", d, 0);
        rd(0, d);   chk("lit_rd0", d, 0);
        step;
        force_data[0 +: FBW] = mk(0, 3, 0, 0, 999);
        force_valid[0] = 1'b1;
        repeat (3) step;
        force_valid[0] = 1'b0;
        rd(3, d);   chk("lit_late_beat", d, 0);
        step;
        pulse_iter;
        for (int it = 0; it < 3; it++) begin
            clear_q;
            repeat (20 + $urandom_range(40)) begin
                l = $urandom_range(NF-1);
                f = ($urandom_range(3) == 0) ? int'($urandom) : int'($urandom_range(2000)) - 1000;
                push(l, mk(1'($urandom_range(1)),
                           ($urandom_range(9) != 0) ? $urandom_range(11) : 100 + $urandom_range(27),
                           int'($urandom_range(2000)) - 1000, f, int'($urandom_range(2000)) - 1000));
            end
            run_lanes(400, "run_rand");
            finish_iter;
            step;
            repeat (150) begin
                cache_rd_en = 1'b1;
                cache_rd_addr = ($urandom_range(7) != 0) ? 7'($urandom_range(13)) : 7'($urandom_range(127));
                step;
            end
            cache_rd_en = 1'b0;
            step;
            pulse_iter;
        end
        step;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/force_cache_accum.md
Name: force_cache_accum

Overview:
Per-cell force accumulator directly downstream of the range-limited filter/force stage. Accepts up to NUM_FILTER force beats per cycle (one per filter lane), grants one per cycle round-robin, and read-modify-write accumulates the 3-component force into a per-particle force cache. After the iteration drains, the motion-update stage reads the cache through a clear-on-read port.

Parameters:
NUM_PARTICLE_PER_CELL, 100, cache depth (valid particle ids 0..N-1)
DATA_WIDTH, 32, one force component, signed two's-complement fixed-point
PARTICLE_ID_WIDTH, 7, particle id / cache address width
NUM_FILTER, 7, number of input force lanes
FORCE_BUFFER_WIDTH, 3*DATA_WIDTH+PARTICLE_ID_WIDTH+1, input beat width
FORCE_CACHE_WIDTH, 3*DATA_WIDTH, cache word {fz,fy,fx}

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (rst==0 resets on the clk edge)
force_data  in  NUM_FILTER*FORCE_BUFFER_WIDTH  lane i at [i*FBW +: FBW]; per beat: bit FBW-1 = sub flag, then particle id, then fz, fy, fx (fx at LSBs)
force_valid  in  NUM_FILTER  lane beat valid; held stable until acked
force_ack  out  NUM_FILTER  one-hot or zero; transfer on valid&ack
reading_done  in  1  upstream has issued its final beat for this iteration
iter_start  in  1  single-cycle pulse, DONE -> ACCUM
accum_done  out  1  cache final and readable
cache_rd_en  in  1  read request (honoured only in DONE)
cache_rd_addr  in  PARTICLE_ID_WIDTH  read address
cache_rd_data  out  FORCE_CACHE_WIDTH  read data
cache_rd_valid  out  1  qualifies cache_rd_data
sat_flag  out  1  sticky: a component saturated
id_error  out  1  sticky: beat with id >= NUM_PARTICLE_PER_CELL

Behaviour:
- Reset: all outputs 0, RR pointer = lane 0, state CLEAR, clear counter 0. Reset mid-operation abandons in-flight beats; no ack issued while rst==0.
- FSM: CLEAR -> ACCUM -> DRAIN -> DONE -> (iter_start) ACCUM.
- CLEAR: writes zero to address 0..NUM_PARTICLE_PER_CELL-1, one per cycle (100 cycles), force_ack=0, then ACCUM.
- ACCUM: force_ack combinational from force_valid; round-robin starting at pointer; after a grant on lane g, pointer = g+1 mod NUM_FILTER; no grant -> pointer unchanged. At most one ack per cycle.
- Datapath: S0 grant + register beat and issue cache read; S1 cache data; S2 add and write. A granted beat is visible to cache_rd 3 cycles after ack. Back-to-back beats to same or nearby ids must produce the exact sum of all beats: forward from S1/S2 in-flight results (no stalls).
- Arithmetic: per component, new = old + f (sub=0) or old - f (sub=1), signed DATA_WIDTH, saturating to 0x7FFFFFFF / 0x80000000; saturation sets sat_flag.
- id >= NUM_PARTICLE_PER_CELL: beat acked and dropped, id_error set, cache unchanged.
- ACCUM -> DRAIN when reading_done==1 and force_valid==0 in the same cycle; DRAIN lasts until S1/S2 empty (2 cycles), then DONE, accum_done=1. force_valid arriving after reading_done is a protocol error: not acked.
- DONE: cache_rd_en -> cache_rd_data/cache_rd_valid 1 cycle later; the addressed entry is written to zero (clear-on-read). Out-of-range read returns 0, valid still asserted. Back-to-back reads of the same address: second returns 0.
- iter_start in DONE: accum_done=0, state ACCUM; sat_flag and id_error cleared. iter_start outside DONE ignored.
- Sticky flags cleared only by reset or iter_start.

Decomposition:
- Shared package: beat field offsets (SUB_BIT, ID_LSB, FX/FY/FZ_LSB), state encoding, saturating-add function.
- One sub-module: rr_arbiter (NUM_FILTER requests, pointer register, one-hot grant).
- Cache as inferred simple dual-port sync RAM inside the top.

Test Plan:
- Reset release -> 100 cycles force_ack=0, then ACCUM; read of any id after drain returns 0.
- Lanes 0,3,6 valid continuously, 3 beats each, id 5, fx=+10 -> acks in order 0,3,6,0,3,6,0,3,6; cache[5].fx=90.
- Back-to-back beats id 7: fx=+100 then sub=1 fx=40, then +1 -> cache[7].fx=61 (forwarding correct).
- cache[2].fx accumulated to 0x7FFFFFF0 then +0x20 -> 0x7FFFFFFF, sat_flag=1; iter_start clears it.
- Beat id 120 -> acked, id_error=1, no cache entry changed.
- reading_done with lanes idle -> accum_done 2 cycles later; read id 5 twice -> {0,0,90} then 0.
